// File: rtl/prio_pkg.sv
// ============================================================================
//  Module      : prio_pkg
//  Description : Shared definitions for the priority arbiter/encoder:
//                default request count, FSM state encoding and an index
//                width helper that never returns zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prio_pkg;

    localparam int PRIO_N_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // $clog2 returns 0 for n=1; a zero-width index is not legal, so clamp to 1.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc_core.sv
// ============================================================================
//  Module      : prio_enc_core
//  Description : Combinational N -> IDXW highest-set-bit priority encoder.
//  Ports       : req   [N-1:0]    request vector
//                found            any request bit set
//                idx   [IDXW-1:0] index of the highest set bit (0 if none)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_core
    import prio_pkg::*;
#(
    parameter int N    = PRIO_N_DEFAULT,
    parameter int IDXW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    assign found = |req;

    // Ascending scan: the last set bit seen (the highest) overrides earlier ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prio_arbiter_enc.sv
// ============================================================================
//  Module      : prio_arbiter_enc
//  Description : Registered priority arbiter/encoder with valid/ready hold.
//                Picks one of N requests, registers the winner as a binary
//                index and a one-hot grant, holds it until handshake, and
//                re-arbitrates back-to-back on handshake.
//  Config      : PRIO_ARB_ROUND_ROBIN_EN - when defined, the search starts at
//                a round-robin pointer and descends with wrap; otherwise pure
//                fixed priority (highest index wins).
//  Ports       : clk, rst_n (async active-low)
//                req        [N-1:0]    request vector
//                gnt_ready             consumer accepts the current grant
//                gnt_valid             grant registers hold a winner
//                gnt_idx    [IDXW-1:0] winner index
//                gnt_onehot [N-1:0]    one-hot winner, 0 when not valid
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_arbiter_enc
    import prio_pkg::*;
#(
    parameter int N = PRIO_N_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               req,
    input  logic                       gnt_ready,
    output logic                       gnt_valid,
    output logic [clog2_min1(N)-1:0]   gnt_idx,
    output logic [N-1:0]               gnt_onehot
);

    localparam int IDXW = clog2_min1(N);

    state_t            state;
    state_t            state_nxt;
    logic              load;
    logic              handshake;
    logic              win_found;
    logic [IDXW-1:0]   win_idx;

    assign gnt_valid = (state == ST_HOLD);
    assign handshake = (state == ST_HOLD) && gnt_ready;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] search_ptr;
    logic [N-1:0]    rot_req;
    logic [IDXW-1:0] rot_idx;

    // On handshake the pointer moves to just below the retiring winner, and
    // the same-edge re-arbitration must already use that new start point.
    always_comb begin
        search_ptr = rr_ptr;
        if (handshake) begin
            search_ptr = (gnt_idx == '0) ? IDXW'(N - 1) : (gnt_idx - IDXW'(1));
        end
    end

    // Rotate so search_ptr lands on the top bit: rot_req[j] = req[(ptr+1+j) mod N].
    // The plain highest-bit encoder then implements the descending wrap search.
    always_comb begin
        int s;
        rot_req = '0;
        for (int j = 0; j < N; j++) begin
            s = int'(search_ptr) + j + 1;
            if (s >= N) begin
                s = s - N;
            end
            rot_req[j] = req[s];
        end
    end

    prio_enc_core #(
        .N    (N),
        .IDXW (IDXW)
    ) u_core (
        .req   (rot_req),
        .found (win_found),
        .idx   (rot_idx)
    );

    always_comb begin
        int s;
        s = int'(search_ptr) + int'(rot_idx) + 1;
        if (s >= N) begin
            s = s - N;
        end
        win_idx = IDXW'(s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IDXW'(N - 1);
        end else if (handshake) begin
            rr_ptr <= search_ptr;
        end
    end
`else
    prio_enc_core #(
        .N    (N),
        .IDXW (IDXW)
    ) u_core (
        .req   (req),
        .found (win_found),
        .idx   (win_idx)
    );
`endif

    // Next-state / load decision
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    load      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Without ready the grant is sticky, whatever req does.
                if (gnt_ready) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt_idx <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                gnt_idx <= win_idx;
            end else if (state_nxt == ST_IDLE) begin
                gnt_idx <= '0;
            end
        end
    end

    // One-hot decode of the registered index, masked by valid.
    generate
        for (genvar i = 0; i < N; i++) begin : g_onehot
            assign gnt_onehot[i] = gnt_valid && (gnt_idx == IDXW'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_prio_arbiter_enc.sv
// ============================================================================
//  Module      : tb_prio_arbiter_enc
//  Description : Self-checking bench for prio_arbiter_enc (N=8). Directed
//                scenarios plus random traffic, checked against a
//                cycle-level behavioural model of the arbitration rules.
//                Honours PRIO_ARB_ROUND_ROBIN_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_arbiter_enc;

    localparam int N    = 8;
    localparam int IDXW = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic            gnt_ready;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_onehot;

    int n_vec;
    int n_err;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    prio_arbiter_enc #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Winner: first requester found walking down from 'start', wrapping N-1 after 0.
    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int s = 0; s < N; s++) begin
            int c;
            c = (start - s + N) % N;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    function automatic bit rr_mode();
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic rdy);
        if (!m_valid) begin
            if (r != '0) begin
                m_valid = 1'b1;
                m_idx   = pick(r, rr_mode() ? m_ptr : N - 1);
            end
        end else if (rdy) begin
            if (rr_mode()) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
            if (r != '0) begin
                m_idx = pick(r, rr_mode() ? m_ptr : N - 1);
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_oh;
        exp_oh = m_valid ? (1 << m_idx) : 0;
        check({tag, ".valid"},  int'(gnt_valid),  int'(m_valid));
        check({tag, ".idx"},    int'(gnt_idx),    m_valid ? m_idx : 0);
        check({tag, ".onehot"}, int'(gnt_onehot), exp_oh);
    endtask

    // One clock: model advances on the inputs present at the edge, outputs
    // are compared 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_edge(req, gnt_ready);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req       = 8'hFF;
        gnt_ready = 1'b0;
        model_reset();

        // 1: reset held with all requests asserted
        #1;
        check_outputs("reset0");
        repeat (3) tick("reset");

        // 2: ladder
        rst_n     = 1'b1;
        gnt_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            req = N'((1 << (k + 1)) - 1);
            tick("ladder");
            if (!rr_mode()) check("ladder.fixed_idx", int'(gnt_idx), k);
        end

        // 3: sticky hold
        req       = 8'h10;
        gnt_ready = 1'b1;
        tick("hold.load");
        check("hold.idx4", int'(gnt_idx), 4);
        gnt_ready = 1'b0;
        tick("hold.w0");
        req = 8'h80;
        repeat (3) tick("hold.sticky");
        check("hold.still4", int'(gnt_idx), 4);
        gnt_ready = 1'b1;
        tick("hold.rel");
        check("hold.idx7", int'(gnt_idx), 7);

        // 4: empty requests, ready toggling
        req = '0;
        for (int i = 0; i < 6; i++) begin
            gnt_ready = i[0];
            tick("empty");
        end
        check("empty.novalid", int'(gnt_valid), 0);
        req = 8'h01;
        tick("empty.req0");
        check("empty.idx0", int'(gnt_idx), 0);

        // 5: all requesting, continuous ready (fresh from reset for a known pointer)
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n     = 1'b1;
        req       = 8'hFF;
        gnt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick("rr");
            check("rr.seq", int'(gnt_idx), rr_mode() ? ((7 - i + 8) % 8) : 7);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req       = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom)
                                                    : N'($urandom);
            if ($urandom_range(0, 7) == 0) req = '0;
            gnt_ready = ($urandom_range(0, 2) != 0);
            tick("rand");
        end

        // 6: async reset mid-HOLD
        req       = '0;
        gnt_ready = 1'b1;
        tick("async.drain");
        req       = 8'h20;
        gnt_ready = 1'b0;
        tick("async.load");
        check("async.idx5", int'(gnt_idx), 5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async.noclk");
        tick("async.held");
        rst_n     = 1'b1;
        req       = 8'hFF;
        gnt_ready = 1'b1;
        tick("async.rearb");
        check("async.idx7", int'(gnt_idx), 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
